// File: rtl/axi_arbiter_pkg.sv
// axi_arbiter_pkg: shared state encodings, master ids and AXI response codes for the read/write arbiter
package axi_arbiter_pkg;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
endpackage

// File: rtl/axi_arb_pick.sv
// axi_arb_pick: two-request read picker; LSU-over-IFU, or round-robin on last_grant when ARB_RR_EN is defined
module axi_arb_pick
  import axi_arbiter_pkg::*;
(
  input  logic ifu_req,
  input  logic lsu_req,
`ifdef ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant
);
  always_comb begin
`ifdef ARB_RR_EN
    grant = (ifu_req && lsu_req) ? !last_grant : (ifu_req ? MST_IFU : MST_LSU);
`else
    grant = (ifu_req && !lsu_req) ? MST_IFU : MST_LSU;
`endif
  end
endmodule

// File: rtl/axi_arbiter.sv
// axi_arbiter: arbitrates IFU/LSU single-beat reads onto one AXI slave and forwards LSU writes.
// Optional ARB_RR_EN selects round-robin read priority instead of fixed LSU-over-IFU.
module axi_arbiter
  import axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_ar_valid,
  output logic                  ifu_ar_ready,
  input  logic [ADDR_W-1:0]     ifu_ar_addr,
  output logic                  ifu_r_valid,
  input  logic                  ifu_r_ready,
  output logic [DATA_W-1:0]     ifu_r_data,
  output logic [1:0]            ifu_r_resp,
  input  logic                  lsu_ar_valid,
  output logic                  lsu_ar_ready,
  input  logic [ADDR_W-1:0]     lsu_ar_addr,
  output logic                  lsu_r_valid,
  input  logic                  lsu_r_ready,
  output logic [DATA_W-1:0]     lsu_r_data,
  output logic [1:0]            lsu_r_resp,
  input  logic                  lsu_aw_valid,
  output logic                  lsu_aw_ready,
  input  logic [ADDR_W-1:0]     lsu_aw_addr,
  input  logic                  lsu_w_valid,
  output logic                  lsu_w_ready,
  input  logic [DATA_W-1:0]     lsu_w_data,
  input  logic [DATA_W/8-1:0]   lsu_w_strb,
  output logic                  lsu_b_valid,
  input  logic                  lsu_b_ready,
  output logic [1:0]            lsu_b_resp,
  output logic                  s_ar_valid,
  input  logic                  s_ar_ready,
  output logic [ADDR_W-1:0]     s_ar_addr,
  input  logic                  s_r_valid,
  output logic                  s_r_ready,
  input  logic [DATA_W-1:0]     s_r_data,
  input  logic [1:0]            s_r_resp,
  output logic                  s_aw_valid,
  input  logic                  s_aw_ready,
  output logic [ADDR_W-1:0]     s_aw_addr,
  output logic                  s_w_valid,
  input  logic                  s_w_ready,
  output logic [DATA_W-1:0]     s_w_data,
  output logic [DATA_W/8-1:0]   s_w_strb,
  input  logic                  s_b_valid,
  output logic                  s_b_ready,
  input  logic [1:0]            s_b_resp
);
  rstate_t rstate, rstate_nxt;
  wstate_t wstate, wstate_nxt;
  logic grant, grant_nxt, pick;
  logic ar_v, r_rdy;
`ifdef ARB_RR_EN
  logic last_grant;
`endif

  assign ar_v  = grant ? lsu_ar_valid : ifu_ar_valid;
  assign r_rdy = grant ? lsu_r_ready : ifu_r_ready;

  axi_arb_pick u_pick (
    .ifu_req    (ifu_ar_valid),
    .lsu_req    (lsu_ar_valid),
`ifdef ARB_RR_EN
    .last_grant (last_grant),
`endif
    .grant      (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate <= R_IDLE;
      wstate <= W_IDLE;
      grant  <= MST_IFU;
`ifdef ARB_RR_EN
      last_grant <= MST_IFU;
`endif
    end else begin
      rstate <= rstate_nxt;
      wstate <= wstate_nxt;
      grant  <= grant_nxt;
`ifdef ARB_RR_EN
      if (rstate == R_DATA && s_r_valid && r_rdy) last_grant <= grant;
`endif
    end
  end

  // A read is only granted when no store is pending, so loads and fetches never pass a store.
  always_comb begin
    rstate_nxt   = rstate;
    grant_nxt    = grant;
    s_ar_valid   = 1'b0;
    s_ar_addr    = '0;
    ifu_ar_ready = 1'b0;
    lsu_ar_ready = 1'b0;
    s_r_ready    = 1'b0;
    ifu_r_valid  = 1'b0;
    ifu_r_data   = '0;
    ifu_r_resp   = OKAY;
    lsu_r_valid  = 1'b0;
    lsu_r_data   = '0;
    lsu_r_resp   = OKAY;
    case (rstate)
      R_IDLE: begin
        if ((ifu_ar_valid || lsu_ar_valid) && wstate == W_IDLE && !lsu_aw_valid) begin
          grant_nxt  = pick;
          rstate_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        s_ar_valid   = ar_v;
        s_ar_addr    = grant ? lsu_ar_addr : ifu_ar_addr;
        ifu_ar_ready = !grant && s_ar_ready;
        lsu_ar_ready = grant && s_ar_ready;
        rstate_nxt   = (ar_v && s_ar_ready) ? R_DATA : (ar_v ? R_ADDR : R_IDLE);
      end
      R_DATA: begin
        s_r_ready   = r_rdy;
        ifu_r_valid = !grant && s_r_valid;
        ifu_r_data  = grant ? '0 : s_r_data;
        ifu_r_resp  = grant ? OKAY : s_r_resp;
        lsu_r_valid = grant && s_r_valid;
        lsu_r_data  = grant ? s_r_data : '0;
        lsu_r_resp  = grant ? s_r_resp : OKAY;
        rstate_nxt  = (s_r_valid && r_rdy) ? R_IDLE : R_DATA;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_nxt   = wstate;
    s_aw_valid   = 1'b0;
    s_aw_addr    = '0;
    lsu_aw_ready = 1'b0;
    s_w_valid    = 1'b0;
    s_w_data     = '0;
    s_w_strb     = '0;
    lsu_w_ready  = 1'b0;
    lsu_b_valid  = 1'b0;
    lsu_b_resp   = OKAY;
    s_b_ready    = 1'b0;
    case (wstate)
      W_IDLE: begin
        s_aw_valid   = lsu_aw_valid;
        s_aw_addr    = lsu_aw_valid ? lsu_aw_addr : '0;
        lsu_aw_ready = lsu_aw_valid && s_aw_ready;
        wstate_nxt   = (lsu_aw_valid && s_aw_ready) ? W_DATA : W_IDLE;
      end
      W_DATA: begin
        s_w_valid   = lsu_w_valid;
        s_w_data    = lsu_w_data;
        s_w_strb    = lsu_w_strb;
        lsu_w_ready = s_w_ready;
        wstate_nxt  = (lsu_w_valid && s_w_ready) ? W_RESP : W_DATA;
      end
      W_RESP: begin
        lsu_b_valid = s_b_valid;
        lsu_b_resp  = s_b_resp;
        s_b_ready   = lsu_b_ready;
        wstate_nxt  = (s_b_valid && lsu_b_ready) ? W_IDLE : W_RESP;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter: randomized scoreboard bench; masters push expected beats, a negedge monitor pops and compares
module tb_axi_arbiter;
  localparam int LIM = 300;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {logic [63:0] d; logic [1:0] r;} rd_t;
  typedef struct packed {logic [63:0] a; logic [63:0] d; logic [7:0] s;} wr_t;

  logic clk = 1'b0, rst = 1'b1;
  logic ifu_ar_valid, ifu_ar_ready, ifu_r_valid, ifu_r_ready;
  logic [63:0] ifu_ar_addr, ifu_r_data;
  logic [1:0] ifu_r_resp;
  logic lsu_ar_valid, lsu_ar_ready, lsu_r_valid, lsu_r_ready;
  logic [63:0] lsu_ar_addr, lsu_r_data;
  logic [1:0] lsu_r_resp;
  logic lsu_aw_valid, lsu_aw_ready, lsu_w_valid, lsu_w_ready, lsu_b_valid, lsu_b_ready;
  logic [63:0] lsu_aw_addr, lsu_w_data;
  logic [7:0] lsu_w_strb;
  logic [1:0] lsu_b_resp;
  logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [63:0] s_ar_addr, s_r_data;
  logic [1:0] s_r_resp;
  logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
  logic [63:0] s_aw_addr, s_w_data;
  logic [7:0] s_w_strb;
  logic [1:0] s_b_resp;

  axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready), .ifu_ar_addr(ifu_ar_addr),
    .ifu_r_valid(ifu_r_valid), .ifu_r_ready(ifu_r_ready), .ifu_r_data(ifu_r_data), .ifu_r_resp(ifu_r_resp),
    .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready), .lsu_ar_addr(lsu_ar_addr),
    .lsu_r_valid(lsu_r_valid), .lsu_r_ready(lsu_r_ready), .lsu_r_data(lsu_r_data), .lsu_r_resp(lsu_r_resp),
    .lsu_aw_valid(lsu_aw_valid), .lsu_aw_ready(lsu_aw_ready), .lsu_aw_addr(lsu_aw_addr),
    .lsu_w_valid(lsu_w_valid), .lsu_w_ready(lsu_w_ready), .lsu_w_data(lsu_w_data), .lsu_w_strb(lsu_w_strb),
    .lsu_b_valid(lsu_b_valid), .lsu_b_ready(lsu_b_ready), .lsu_b_resp(lsu_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp)
  );

  int pass_cnt = 0, total_cnt = 0, cyc = 0;
  bit rand_mode = 1'b0, rd_hold = 1'b0;
  int b_delay = 0;
  rd_t ifu_q[$], lsu_q[$];
  wr_t wq[$];
  logic [1:0] bq[$];
  int done_q[$];
  int ar_rise_cyc = 0, r_hs_cyc = 0, b_hs_cyc = 0, last_gap = 0, ifu_issue_cyc = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run still active after 60000 cycles, required completion");
    $fatal(1);
  end

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    return (a == 64'h8000_0000) ? 64'h00000013_00000297 : {a[31:0] ^ 32'h5a5a_1234, ~a[31:0] + 32'd7};
  endfunction
  function automatic logic [1:0] resp_of(input logic [63:0] a);
    return a[5] ? {1'b1, a[4]} : 2'b00;
  endfunction
  function automatic logic [63:0] rnd_addr();
    return {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_fff0)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask
  task automatic timeout(input string nm);
    total_cnt++;
    $display("FAIL %s: no handshake within %0d cycles, required one", nm, LIM);
  endtask

  // bench-side slave: read channel
  logic rd_pend = 1'b0;
  logic [63:0] rd_addr = '0;
  int rd_wait = 0;
  initial begin
    s_ar_ready = 0; s_r_valid = 0; s_r_data = 0; s_r_resp = 0;
    forever begin
      @(negedge clk);
      if (rst) rd_pend = 1'b0;
      else begin
        if (s_r_valid && s_r_ready) rd_pend = 1'b0;
        if (s_ar_valid && s_ar_ready) begin
          rd_pend = 1'b1;
          rd_addr = s_ar_addr;
          rd_wait = rd_hold ? 1000 : (rand_mode ? int'($urandom_range(0, 3)) : 0);
        end else if (rd_pend && rd_wait > 0) rd_wait--;
      end
      @(posedge clk); #1;
      s_ar_ready = !rd_pend && (!rand_mode || $urandom_range(0, 1) == 1);
      s_r_valid  = rd_pend && rd_wait == 0;
      s_r_data   = s_r_valid ? mem_data(rd_addr) : '0;
      s_r_resp   = s_r_valid ? resp_of(rd_addr) : 2'b00;
    end
  end

  // bench-side slave: write channels, checks forwarded aw/w against issued stores
  logic wa = 1'b0, bp = 1'b0;
  logic [63:0] wa_addr = '0;
  int bcnt = 0;
  initial begin
    wr_t e;
    s_aw_ready = 0; s_w_ready = 0; s_b_valid = 0; s_b_resp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin wa = 1'b0; bp = 1'b0; end
      else begin
        if (s_b_valid && s_b_ready) bp = 1'b0;
        else if (bp && bcnt > 0) bcnt--;
        if (s_w_valid && s_w_ready) begin
          if (wq.size() == 0) begin total_cnt++; $display("FAIL s_w_unexpected: got data %h, required none", s_w_data); end
          else begin
            e = wq.pop_front();
            chk("s_aw_addr", wa_addr, e.a);
            chk("s_w_data", s_w_data, e.d);
            chk("s_w_strb", 64'(s_w_strb), 64'(e.s));
          end
          wa = 1'b0; bp = 1'b1;
          bcnt = rand_mode ? int'($urandom_range(0, 5)) : b_delay;
        end
        if (s_aw_valid && s_aw_ready) begin wa = 1'b1; wa_addr = s_aw_addr; end
      end
      @(posedge clk); #1;
      s_aw_ready = !wa && !bp && (!rand_mode || $urandom_range(0, 1) == 1);
      s_w_ready  = wa && (!rand_mode || $urandom_range(0, 1) == 1);
      s_b_valid  = bp && bcnt == 0;
      s_b_resp   = s_b_valid ? resp_of(wa_addr) : 2'b00;
    end
  end

  initial begin
    ifu_r_ready = 1; lsu_r_ready = 1; lsu_b_ready = 1;
    forever begin
      @(posedge clk); #1;
      ifu_r_ready = !rand_mode || $urandom_range(0, 1) == 1;
      lsu_r_ready = !rand_mode || $urandom_range(0, 1) == 1;
      lsu_b_ready = !rand_mode || $urandom_range(0, 1) == 1;
    end
  end

  // monitor: pops expected beats and watches ordering against outstanding stores
  logic ar_prev = 1'b0, busy_prev = 1'b0, wr_out = 1'b0, busy_now;
  initial forever begin
    rd_t e;
    @(negedge clk);
    if (rst) begin ar_prev = 0; busy_prev = 0; wr_out = 0; end
    else begin
      busy_now = lsu_aw_valid || wr_out;
      if (s_ar_valid && !ar_prev) begin
        ar_rise_cyc = cyc;
        last_gap = cyc - r_hs_cyc;
        chk("grant_during_write", 64'(busy_prev), 64'd0);
      end
      ar_prev = s_ar_valid;
      busy_prev = busy_now;
      if (lsu_aw_valid && lsu_aw_ready) wr_out = 1'b1;
      if (ifu_r_valid || lsu_r_valid) chk("r_exclusive", 64'(ifu_r_valid && lsu_r_valid), 64'd0);
      if (lsu_b_valid && lsu_b_ready) begin
        wr_out = 1'b0;
        b_hs_cyc = cyc;
        if (bq.size() == 0) begin total_cnt++; $display("FAIL lsu_b_unexpected: got resp %b, required none", lsu_b_resp); end
        else chk("lsu_b_resp", 64'(lsu_b_resp), 64'(bq.pop_front()));
      end
      if (ifu_r_valid && ifu_r_ready) begin
        r_hs_cyc = cyc;
        done_q.push_back(0);
        if (ifu_q.size() == 0) begin total_cnt++; $display("FAIL ifu_r_unexpected: got %h, required none", ifu_r_data); end
        else begin
          e = ifu_q.pop_front();
          chk("ifu_r_data", ifu_r_data, e.d);
          chk("ifu_r_resp", 64'(ifu_r_resp), 64'(e.r));
        end
      end
      if (lsu_r_valid && lsu_r_ready) begin
        r_hs_cyc = cyc;
        done_q.push_back(1);
        if (lsu_q.size() == 0) begin total_cnt++; $display("FAIL lsu_r_unexpected: got %h, required none", lsu_r_data); end
        else begin
          e = lsu_q.pop_front();
          chk("lsu_r_data", lsu_r_data, e.d);
          chk("lsu_r_resp", 64'(lsu_r_resp), 64'(e.r));
        end
      end
    end
  end

  task automatic ifu_read(input logic [63:0] a);
    int n = 0;
    ifu_q.push_back(rd_t'{mem_data(a), resp_of(a)});
    ifu_issue_cyc = cyc;
    ifu_ar_valid = 1; ifu_ar_addr = a;
    do begin @(negedge clk); n++; end while (!ifu_ar_ready && n < LIM);
    if (!ifu_ar_ready) timeout("ifu_ar");
    @(posedge clk); #1;
    ifu_ar_valid = 0; ifu_ar_addr = 0;
    n = 0;
    while (ifu_q.size() != 0 && n < LIM) begin @(negedge clk); n++; end
    if (ifu_q.size() != 0) begin timeout("ifu_r"); ifu_q.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic lsu_read(input logic [63:0] a);
    int n = 0;
    lsu_q.push_back(rd_t'{mem_data(a), resp_of(a)});
    lsu_ar_valid = 1; lsu_ar_addr = a;
    do begin @(negedge clk); n++; end while (!lsu_ar_ready && n < LIM);
    if (!lsu_ar_ready) timeout("lsu_ar");
    @(posedge clk); #1;
    lsu_ar_valid = 0; lsu_ar_addr = 0;
    n = 0;
    while (lsu_q.size() != 0 && n < LIM) begin @(negedge clk); n++; end
    if (lsu_q.size() != 0) begin timeout("lsu_r"); lsu_q.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic lsu_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    wq.push_back(wr_t'{a, d, s});
    bq.push_back(resp_of(a));
    lsu_aw_valid = 1; lsu_aw_addr = a;
    do begin @(negedge clk); n++; end while (!lsu_aw_ready && n < LIM);
    if (!lsu_aw_ready) timeout("lsu_aw");
    @(posedge clk); #1;
    lsu_aw_valid = 0; lsu_aw_addr = 0;
    lsu_w_valid = 1; lsu_w_data = d; lsu_w_strb = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!lsu_w_ready && n < LIM);
    if (!lsu_w_ready) timeout("lsu_w");
    @(posedge clk); #1;
    lsu_w_valid = 0; lsu_w_data = 0; lsu_w_strb = 0;
    n = 0;
    while (bq.size() != 0 && n < LIM) begin @(negedge clk); n++; end
    if (bq.size() != 0) begin timeout("lsu_b"); bq.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    chk({nm, "_valid_ready"}, 64'({s_ar_valid, s_r_ready, s_aw_valid, s_w_valid, s_b_ready, ifu_ar_ready,
        lsu_ar_ready, ifu_r_valid, lsu_r_valid, lsu_aw_ready, lsu_w_ready, lsu_b_valid}), 64'd0);
    chk({nm, "_addr"}, s_ar_addr | s_aw_addr, 64'd0);
    chk({nm, "_data"}, s_w_data | ifu_r_data | lsu_r_data, 64'd0);
    chk({nm, "_resp_strb"}, 64'({ifu_r_resp, lsu_r_resp, lsu_b_resp, s_w_strb}), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    ifu_ar_valid = 0; ifu_ar_addr = 0; lsu_ar_valid = 0; lsu_ar_addr = 0;
    lsu_aw_valid = 0; lsu_aw_addr = 0; lsu_w_valid = 0; lsu_w_data = 0; lsu_w_strb = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check_idle("reset");

    ifu_read(64'h8000_0000);
    chk("ifu_only_latency", 64'(ar_rise_cyc - ifu_issue_cyc), 64'd1);

    lsu_read(64'h8000_1100);
    done_q.delete();
    fork
      ifu_read(64'h8000_0000);
      lsu_read(64'h8000_1000);
    join
    chk("simul_count", 64'(done_q.size()), 64'd2);
    if (done_q.size() > 0) chk("simul_first_winner", 64'(done_q[0]), RR ? 64'd0 : 64'd1);
    chk("simul_second_gap", 64'(last_gap), 64'd2);

    b_delay = 5;
    fork
      lsu_write(64'h8000_2000, 64'h1122_3344_5566_7788, 8'hF0);
      ifu_read(64'h8000_0010);
    join
    chk("read_after_b_gap", 64'(ar_rise_cyc - b_hs_cyc), 64'd2);
    b_delay = 0;

    lsu_read(64'h8000_1020);
    ifu_read(64'h8000_0100);
    chk("after_slverr_latency", 64'(ar_rise_cyc - ifu_issue_cyc), 64'd1);

    begin
      int n = 0;
      rd_hold = 1;
      ifu_ar_valid = 1; ifu_ar_addr = 64'h8000_0040;
      do begin @(negedge clk); n++; end while (!ifu_ar_ready && n < LIM);
      if (!ifu_ar_ready) timeout("rst_ar");
      @(posedge clk); #1;
      ifu_ar_valid = 0; ifu_ar_addr = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1;
      rst = 0; rd_hold = 0;
      check_idle("mid_reset");
    end
    ifu_read(64'h8000_0200);
    chk("post_reset_latency", 64'(ar_rise_cyc - ifu_issue_cyc), 64'd1);

    rand_mode = 1;
    for (int it = 0; it < 200; it++) begin
      fork
        begin
          if ($urandom_range(0, 2) != 0) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            ifu_read(rnd_addr());
          end
        end
        begin
          int k = $urandom_range(0, 2);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          if (k == 0) lsu_read(rnd_addr());
          else if (k == 1) lsu_write(rnd_addr(), {$urandom, $urandom}, 8'($urandom));
        end
      join
    end
    rand_mode = 0;
    repeat (5) @(posedge clk);
    chk("drain_queues", 64'(ifu_q.size() + lsu_q.size() + wq.size() + bq.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/axi_arbiter.md
Name: axi_arbiter

Overview:
- Sits between the core's two AXI masters (IFU: read-only; LSU: read and write) and the single downstream AXI slave port (memory/crossbar).
- Arbitrates the read address/data channels between IFU and LSU and forwards LSU writes.
- Holds each read grant until its R beat completes; single-beat transfers only, no IDs, no bursts.
- Blocks new read grants while an LSU write is outstanding, so a fetch or load never overtakes a store.

Parameters:
- ADDR_W, 64, address width of all AR/AW channels
- DATA_W, 64, data width of R/W channels; strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ifu_ar_valid/ifu_ar_ready  in/out  1  IFU read address handshake
- ifu_ar_addr  in  ADDR_W  IFU read address
- ifu_r_valid/ifu_r_ready  out/in  1  IFU read data handshake
- ifu_r_data  out  DATA_W  IFU read data
- ifu_r_resp  out  2  IFU read response
- lsu_ar_valid/lsu_ar_ready  in/out  1  LSU read address handshake
- lsu_ar_addr  in  ADDR_W  LSU read address
- lsu_r_valid/lsu_r_ready  out/in  1  LSU read data handshake
- lsu_r_data  out  DATA_W  LSU read data
- lsu_r_resp  out  2  LSU read response
- lsu_aw_valid/lsu_aw_ready  in/out  1  write address handshake
- lsu_aw_addr  in  ADDR_W  write address
- lsu_w_valid/lsu_w_ready  in/out  1  write data handshake
- lsu_w_data  in  DATA_W  write data
- lsu_w_strb  in  DATA_W/8  write byte strobes
- lsu_b_valid/lsu_b_ready  out/in  1  write response handshake
- lsu_b_resp  out  2  write response
- s_ar_valid, s_ar_ready, s_ar_addr  out/in/out  1/1/ADDR_W  slave read address channel
- s_r_valid, s_r_ready, s_r_data, s_r_resp  in/out/in/in  1/1/DATA_W/2  slave read data channel
- s_aw_valid, s_aw_ready, s_aw_addr  out/in/out  1/1/ADDR_W  slave write address channel
- s_w_valid, s_w_ready, s_w_data, s_w_strb  out/in/out/out  1/1/DATA_W/DATA_W/8  slave write data channel
- s_b_valid, s_b_ready, s_b_resp  in/out/in  1/1/2  slave write response channel

Behaviour:
- Reset: rstate=R_IDLE, wstate=W_IDLE, grant=IFU, last_grant=IFU. All valid/ready outputs are 0 and all data/addr outputs are 0 while in idle.
- Read FSM has three states.
  - R_IDLE: grant is taken when (ifu_ar_valid | lsu_ar_valid) & wstate==W_IDLE & !lsu_aw_valid. The winner is latched into grant and the FSM goes to R_ADDR. Fixed priority: LSU beats IFU.
  - R_ADDR: s_ar_valid and s_ar_addr come from the granted master; that master's ar_ready = s_ar_ready; the other master's ar_ready = 0. On the s_ar handshake go to R_DATA. If the granted master drops ar_valid without a handshake, go back to R_IDLE.
  - R_DATA: s_r_* is routed to the granted master and s_r_ready = that master's r_ready. The other master sees r_valid=0 and r_data=0. On s_r_valid & s_r_ready go to R_IDLE.
- Latency: one-cycle arbitration bubble. The earliest s_ar_valid is the cycle after the master's ar_valid.
- Back-to-back reads: R_IDLE is re-entered for at least one cycle between grants.
- Write FSM has three states; writes come only from the LSU and are forwarded combinationally.
  - W_IDLE: s_aw = lsu_aw. On the aw handshake go to W_DATA.
  - W_DATA: s_w = lsu_w. On the w handshake go to W_RESP. While in W_DATA, s_aw_valid=0.
  - W_RESP: lsu_b = s_b. On the b handshake go to W_IDLE.
  - Channel signals not belonging to the current state are forced to 0.
- Read/write interaction:
  - A write request arriving while a read is granted is accepted on the write FSM; the read is not aborted.
  - New read grants stall while wstate != W_IDLE.
- A slave response of SLVERR/DECERR is passed through unchanged; the arbiter never generates responses itself.
- Reset mid-transaction: all FSMs return to idle next edge; in-flight slave beats are dropped (the slave is reset on the same rst).

Optional Feature:
- ARB_RR_EN defined: round-robin read priority. last_grant records the master of the most recent completed R beat; on a simultaneous request the other master wins.
- ARB_RR_EN undefined: fixed LSU-over-IFU priority and no last_grant register.

Decomposition:
- Shared package holds:
  - read state encodings: R_IDLE, R_ADDR, R_DATA
  - write state encodings: W_IDLE, W_DATA, W_RESP
  - master id constants: MST_IFU=0, MST_LSU=1
  - AXI response constants: OKAY, SLVERR, DECERR
- One natural sub-module, axi_arb_pick: combinational two-request picker with optional round-robin input last_grant; outputs a grant id.

Test Plan:
- IFU only: ifu_ar_valid=1, addr 0x80000000; slave answers r_data 0x00000013_00000297 with 0 wait states. Expect s_ar_valid at cycle +1, ifu_r_valid with that data, lsu_r_valid=0 throughout.
- Simultaneous IFU/LSU ar_valid, fixed priority: LSU addr 0x80001000 granted first. IFU is granted after the LSU R beat plus one idle cycle.
- Same as the previous scenario with ARB_RR_EN and last_grant=LSU: IFU granted first.
- LSU store aw 0x80002000, strb 0xF0, slave b delayed 5 cycles, with IFU ar_valid asserted at aw time. s_ar_valid must stay 0 until the cycle after the b handshake.
- Slave returns r_resp=2'b10 for an LSU load: lsu_r_resp=2'b10, the FSM returns to R_IDLE, and the next IFU read proceeds normally.
- rst asserted while in R_DATA: on the next cycle all outputs are 0 and both FSMs are idle; a fresh IFU read then completes correctly.
